flex_down_timer: RTL and testbench

- Loadable down-counting timer. It complements the up-counting flex counter: it is loaded with a period, counts down to zero, and reports expiry.
- Used by protocol FSMs for bit-time and timeout waits: start a wait, poll or wait for done, then acknowledge.
- Contains a 3-state control FSM (IDLE/RUN/DONE), a start/done/ack handshake, abort, and a latched period register.

---
 rtl/flex_down_timer.sv | 145 ++++++++++++++
 tb/tb_flex_down_timer.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flex_down_timer.sv
// flex_down_timer: loadable down-counting timer with a start/done/ack handshake.
//
// A start in IDLE (or DONE) latches load_val into the period register and begins
// a wait of load_val enabled ticks. When the count reaches zero the timer pulses
// expire_flag for one cycle and raises done. done is held until ack, start or
// abort. A zero load_val goes straight to DONE with an expiry pulse.
//
// Optional build macro: FLEX_DOWN_TIMER_RELOAD_EN
//   When defined, each expiry in RUN reloads the counter from the period
//   register and the timer stays in RUN, giving a periodic expire_flag.
//   When undefined, the timer is single-shot.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   start        load load_val and begin counting (ignored in RUN)
//   load_val     period value, sampled only on an accepted start
//   count_enable decrement qualifier while in RUN
//   abort        cancel and return to IDLE (RUN/DONE)
//   ack          acknowledge done, DONE -> IDLE
//   count_out    remaining count
//   busy         high in RUN
//   done         high in DONE
//   expire_flag  one-cycle pulse per expiry

module flex_down_timer #(
  parameter int unsigned NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [NUM_CNT_BITS-1:0] load_val,
  input  logic                    count_enable,
  input  logic                    abort,
  input  logic                    ack,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    busy,
  output logic                    done,
  output logic                    expire_flag
);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } state_e;

  localparam logic [NUM_CNT_BITS-1:0] CntZero = '0;
  localparam logic [NUM_CNT_BITS-1:0] CntOne  = NUM_CNT_BITS'(1);

  state_e                  state_q, state_d;
  logic [NUM_CNT_BITS-1:0] count_q, count_d;
  logic [NUM_CNT_BITS-1:0] period_q, period_d;
  logic                    expire_q, expire_d;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    period_d = period_q;
    expire_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          period_d = load_val;
          if (load_val != CntZero) begin
            count_d = load_val;
            state_d = StRun;
          end else begin
            // Zero-length wait: expire immediately.
            count_d  = CntZero;
            state_d  = StDone;
            expire_d = 1'b1;
          end
        end
      end

      StRun: begin
        if (abort) begin
          count_d = CntZero;
          state_d = StIdle;
        end else if (count_enable) begin
          if (count_q > CntOne) begin
            count_d = count_q - CntOne;
          end else begin
            // count_q is 1 here; 0 cannot occur in RUN but is treated as expiry too.
            expire_d = 1'b1;
`ifdef FLEX_DOWN_TIMER_RELOAD_EN
            count_d = period_q;
`else
            count_d = CntZero;
            state_d = StDone;
`endif
          end
        end
      end

      StDone: begin
        if (abort) begin
          count_d = CntZero;
          state_d = StIdle;
        end else if (start) begin
          // Back-to-back wait: reload exactly as from IDLE.
          period_d = load_val;
          if (load_val != CntZero) begin
            count_d = load_val;
            state_d = StRun;
          end else begin
            count_d  = CntZero;
            state_d  = StDone;
            expire_d = 1'b1;
          end
        end else if (ack) begin
          count_d = CntZero;
          state_d = StIdle;
        end
      end

      default: begin
        count_d = CntZero;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      count_q  <= CntZero;
      period_q <= CntZero;
      expire_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      period_q <= period_d;
      expire_q <= expire_d;
    end
  end

  assign count_out   = count_q;
  assign busy        = (state_q == StRun);
  assign done        = (state_q == StDone);
  assign expire_flag = expire_q;

endmodule

// File: tb/tb_flex_down_timer.sv
// Directed self-checking bench for flex_down_timer (NUM_CNT_BITS = 4).
// Observed vector obs = {count_out, busy, done, expire_flag}.

module tb_flex_down_timer;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] load_val;
  logic       count_enable;
  logic       abort;
  logic       ack;
  logic [3:0] count_out;
  logic       busy;
  logic       done;
  logic       expire_flag;
  logic [6:0] obs;

  int n_cmp;
  int n_bad;

  flex_down_timer #(
    .NUM_CNT_BITS(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .load_val    (load_val),
    .count_enable(count_enable),
    .abort       (abort),
    .ack         (ack),
    .count_out   (count_out),
    .busy        (busy),
    .done        (done),
    .expire_flag (expire_flag)
  );

  assign obs = {count_out, busy, done, expire_flag};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_cmp++;
    if (obs !== 7'b0000_000) begin
      n_bad++;
      $display("FAIL reset_state: got %b want %b", obs, 7'b0000_000);
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++;
      if (obs !== 7'b0000_000) begin
        n_bad++;
        $display("FAIL reset_idle[%0d]: got %b want %b", i, obs, 7'b0000_000);
      end
    end
  endtask

  task automatic test_basic();
    logic [6:0] exp_v [5];
    exp_v[0] = {4'd3, 3'b100};
    exp_v[1] = {4'd2, 3'b100};
    exp_v[2] = {4'd1, 3'b100};
    exp_v[3] = {4'd0, 3'b011};
    exp_v[4] = {4'd0, 3'b010};
    start        = 1'b1;
    load_val     = 4'd3;
    count_enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      start = 1'b0;
      n_cmp++;
      if (obs !== exp_v[i]) begin
        n_bad++;
        $display("FAIL basic[%0d]: got %b want %b", i, obs, exp_v[i]);
      end
    end
    count_enable = 1'b0;
    ack = 1'b1;
    step();
    ack = 1'b0;
    n_cmp++;
    if (obs !== 7'b0000_000) begin
      n_bad++;
      $display("FAIL basic_ack: got %b want %b", obs, 7'b0000_000);
    end
  endtask

  task automatic test_gated();
    logic [3:0] exp_cnt [6];
    logic [6:0] exp_v;
    exp_cnt[0] = 4'd2; exp_cnt[1] = 4'd2; exp_cnt[2] = 4'd1;
    exp_cnt[3] = 4'd1; exp_cnt[4] = 4'd1; exp_cnt[5] = 4'd0;
    count_enable = 1'b0;
    start        = 1'b1;
    load_val     = 4'd2;
    step();
    start = 1'b0;
    n_cmp++;
    if (obs !== {4'd2, 3'b100}) begin
      n_bad++;
      $display("FAIL gated_load: got %b want %b", obs, {4'd2, 3'b100});
    end
    for (int i = 0; i < 6; i++) begin
      count_enable = (i % 3 == 2);
      step();
      exp_v = (i == 5) ? {4'd0, 3'b011} : {exp_cnt[i], 3'b100};
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL gated[%0d]: got %b want %b", i, obs, exp_v);
      end
    end
    count_enable = 1'b0;
    step();
    n_cmp++;
    if (obs !== {4'd0, 3'b010}) begin
      n_bad++;
      $display("FAIL gated_hold: got %b want %b", obs, {4'd0, 3'b010});
    end
    ack = 1'b1;
    step();
    ack = 1'b0;
  endtask

  task automatic test_zero_abort();
    start    = 1'b1;
    load_val = 4'd0;
    step();
    start = 1'b0;
    n_cmp++;
    if (obs !== {4'd0, 3'b011}) begin
      n_bad++;
      $display("FAIL zero_load: got %b want %b", obs, {4'd0, 3'b011});
    end
    step();
    n_cmp++;
    if (obs !== {4'd0, 3'b010}) begin
      n_bad++;
      $display("FAIL zero_hold: got %b want %b", obs, {4'd0, 3'b010});
    end
    ack = 1'b1;
    step();
    ack = 1'b0;
    n_cmp++;
    if (obs !== 7'b0000_000) begin
      n_bad++;
      $display("FAIL zero_ack: got %b want %b", obs, 7'b0000_000);
    end
    // Load 9, count down to 5, then abort.
    start        = 1'b1;
    load_val     = 4'd9;
    count_enable = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    n_cmp++;
    if (obs !== {4'd5, 3'b100}) begin
      n_bad++;
      $display("FAIL abort_pre: got %b want %b", obs, {4'd5, 3'b100});
    end
    abort = 1'b1;
    step();
    abort        = 1'b0;
    count_enable = 1'b0;
    n_cmp++;
    if (obs !== 7'b0000_000) begin
      n_bad++;
      $display("FAIL abort_run: got %b want %b", obs, 7'b0000_000);
    end
    step();
    n_cmp++;
    if (obs !== 7'b0000_000) begin
      n_bad++;
      $display("FAIL abort_after: got %b want %b", obs, 7'b0000_000);
    end
  endtask

  task automatic test_simultaneous();
    // Reach DONE with load 1.
    start        = 1'b1;
    load_val     = 4'd1;
    count_enable = 1'b1;
    step();
    start = 1'b0;
    step();
    count_enable = 1'b0;
    n_cmp++;
    if (obs !== {4'd0, 3'b011}) begin
      n_bad++;
      $display("FAIL simul_done: got %b want %b", obs, {4'd0, 3'b011});
    end
    // start beats ack in DONE.
    start    = 1'b1;
    ack      = 1'b1;
    load_val = 4'd4;
    step();
    start = 1'b0;
    ack   = 1'b0;
    n_cmp++;
    if (obs !== {4'd4, 3'b100}) begin
      n_bad++;
      $display("FAIL simul_start_ack: got %b want %b", obs, {4'd4, 3'b100});
    end
    count_enable = 1'b1;
    for (int i = 0; i < 3; i++) step();
    n_cmp++;
    if (obs !== {4'd1, 3'b100}) begin
      n_bad++;
      $display("FAIL simul_cnt1: got %b want %b", obs, {4'd1, 3'b100});
    end
    // abort beats count_enable at count 1: no expiry.
    abort = 1'b1;
    step();
    abort        = 1'b0;
    count_enable = 1'b0;
    n_cmp++;
    if (obs !== 7'b0000_000) begin
      n_bad++;
      $display("FAIL simul_abort_ce: got %b want %b", obs, 7'b0000_000);
    end
    // start ignored in RUN.
    start    = 1'b1;
    load_val = 4'd3;
    step();
    load_val = 4'd7;
    step();
    n_cmp++;
    if (obs !== {4'd3, 3'b100}) begin
      n_bad++;
      $display("FAIL simul_restart_idle: got %b want %b", obs, {4'd3, 3'b100});
    end
    count_enable = 1'b1;
    step();
    start = 1'b0;
    n_cmp++;
    if (obs !== {4'd2, 3'b100}) begin
      n_bad++;
      $display("FAIL simul_restart_cnt: got %b want %b", obs, {4'd2, 3'b100});
    end
    step();
    step();
    count_enable = 1'b0;
    n_cmp++;
    if (obs !== {4'd0, 3'b011}) begin
      n_bad++;
      $display("FAIL simul_expire: got %b want %b", obs, {4'd0, 3'b011});
    end
    ack = 1'b1;
    step();
    ack = 1'b0;
  endtask

  task automatic test_reload();
    int         pulses;
    logic [6:0] exp_v;
    pulses       = 0;
    start        = 1'b1;
    load_val     = 4'd2;
    count_enable = 1'b1;
    step();
    start = 1'b0;
    n_cmp++;
    if (obs !== {4'd2, 3'b100}) begin
      n_bad++;
      $display("FAIL reload_load: got %b want %b", obs, {4'd2, 3'b100});
    end
    for (int i = 0; i < 10; i++) begin
      step();
      exp_v = (i % 2 == 1) ? {4'd2, 3'b101} : {4'd1, 3'b100};
      if (expire_flag === 1'b1) pulses++;
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL reload[%0d]: got %b want %b", i, obs, exp_v);
      end
    end
    n_cmp++;
    if (pulses !== 5) begin
      n_bad++;
      $display("FAIL reload_pulses: got %0d want %0d", pulses, 5);
    end
    count_enable = 1'b0;
    abort        = 1'b1;
    step();
    abort = 1'b0;
    n_cmp++;
    if (obs !== 7'b0000_000) begin
      n_bad++;
      $display("FAIL reload_abort: got %b want %b", obs, 7'b0000_000);
    end
  endtask

  initial begin
    n_cmp        = 0;
    n_bad        = 0;
    rst          = 1'b1;
    start        = 1'b0;
    load_val     = 4'd0;
    count_enable = 1'b0;
    abort        = 1'b0;
    ack          = 1'b0;
    #1;
    test_reset();
`ifdef FLEX_DOWN_TIMER_RELOAD_EN
    test_zero_abort();
    test_reload();
`else
    test_basic();
    test_gated();
    test_zero_abort();
    test_simultaneous();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
